// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared state, pattern mode and colour definitions for the video pattern generator
package vid_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [2:0] MODE_SOLID = 3'd0;
    localparam logic [2:0] MODE_BARS  = 3'd1;
    localparam logic [2:0] MODE_GRAD  = 3'd2;
    localparam logic [2:0] MODE_GRID  = 3'd3;
    localparam logic [2:0] MODE_CHECK = 3'd4;
    localparam logic [2:0] MODE_CYCLE = 3'd5;

    // One bit per channel {B,G,R}; each bit is replicated to CW bits at the point of use.
    localparam logic [2:0] WHITE   = 3'b111;
    localparam logic [2:0] YELLOW  = 3'b011;
    localparam logic [2:0] CYAN    = 3'b110;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] RED     = 3'b001;
    localparam logic [2:0] BLUE    = 3'b100;
    localparam logic [2:0] BLACK   = 3'b000;

    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = WHITE;
            3'd1:    bar_colour = YELLOW;
            3'd2:    bar_colour = CYAN;
            3'd3:    bar_colour = GREEN;
            3'd4:    bar_colour = MAGENTA;
            3'd5:    bar_colour = RED;
            3'd6:    bar_colour = BLUE;
            default: bar_colour = BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vid_timing_core.sv
// rtl/vid_timing_core.sv - h/v counters, frame-boundary config shadows and sync/active decode
module vid_timing_core
    import vid_pkg::*;
#(
    parameter int TW = 12,
    parameter int CW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [TW-1:0]   h_total_i,
    input  logic [TW-1:0]   h_sync_i,
    input  logic [TW-1:0]   h_bporch_i,
    input  logic [TW-1:0]   h_res_i,
    input  logic [TW-1:0]   v_total_i,
    input  logic [TW-1:0]   v_sync_i,
    input  logic [TW-1:0]   v_bporch_i,
    input  logic [TW-1:0]   v_res_i,
    input  logic [2:0]      mode_i,
    input  logic [3*CW-1:0] fg_rgb_i,
    output logic            hs_o,
    output logic            vs_o,
    output logic            de_o,
    output logic            busy_o,
    output logic            frame_start_o,
    output logic [TW-1:0]   x_o,
    output logic [4:0]      y_o,
    output logic [TW-1:0]   bar_w_o,
    output logic [2:0]      mode_o,
    output logic [3*CW-1:0] fg_rgb_o
);

    localparam logic [TW-1:0] ONE = TW'(1);

    state_e          state_q, state_d;
    logic [TW-1:0]   h_q, h_d, v_q, v_d;
    logic [TW-1:0]   h_total_q, h_sync_q, h_bporch_q, h_res_q;
    logic [TW-1:0]   v_total_q, v_sync_q, v_bporch_q, v_res_q;
    logic [TW-1:0]   bar_w_q;
    logic [2:0]      mode_q;
    logic [3*CW-1:0] fg_q;
    logic            latch;

    // The frame boundary is the only place a stop or a config change can take effect.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (en_i) begin
                    state_d = RUN;
                    latch   = 1'b1;
                end
            end
            RUN: begin
                if (h_q == h_total_q - ONE) begin
                    h_d = '0;
                    if (v_q == v_total_q - ONE) begin
                        v_d = '0;
                        if (en_i) latch = 1'b1;
                        else      state_d = IDLE;
                    end else begin
                        v_d = v_q + ONE;
                    end
                end else begin
                    h_d = h_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            h_q        <= '0;
            v_q        <= '0;
            h_total_q  <= '0;
            h_sync_q   <= '0;
            h_bporch_q <= '0;
            h_res_q    <= '0;
            v_total_q  <= '0;
            v_sync_q   <= '0;
            v_bporch_q <= '0;
            v_res_q    <= '0;
            bar_w_q    <= '0;
            mode_q     <= '0;
            fg_q       <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            if (latch) begin
                h_total_q  <= h_total_i;
                h_sync_q   <= h_sync_i;
                h_bporch_q <= h_bporch_i;
                h_res_q    <= h_res_i;
                v_total_q  <= v_total_i;
                v_sync_q   <= v_sync_i;
                v_bporch_q <= v_bporch_i;
                v_res_q    <= v_res_i;
                bar_w_q    <= h_res_i >> 3;
                mode_q     <= mode_i;
                fg_q       <= fg_rgb_i;
            end
        end
    end

    logic          run;
    logic [TW:0]   h_act_s, h_act_e, v_act_s, v_act_e;

    assign run     = (state_q == RUN);
    assign h_act_s = {1'b0, h_sync_q} + {1'b0, h_bporch_q};
    assign h_act_e = h_act_s + {1'b0, h_res_q};
    assign v_act_s = {1'b0, v_sync_q} + {1'b0, v_bporch_q};
    assign v_act_e = v_act_s + {1'b0, v_res_q};

    assign hs_o          = run && (h_q < h_sync_q);
    assign vs_o          = run && (v_q < v_sync_q);
    assign de_o          = run && ({1'b0, h_q} >= h_act_s) && ({1'b0, h_q} < h_act_e)
                               && ({1'b0, v_q} >= v_act_s) && ({1'b0, v_q} < v_act_e);
    assign busy_o        = run;
    assign frame_start_o = run && (h_q == '0) && (v_q == '0);
    assign x_o           = h_q - h_act_s[TW-1:0];
    assign y_o           = v_q[4:0] - v_act_s[4:0];
    assign bar_w_o       = bar_w_q;
    assign mode_o        = mode_q;
    assign fg_rgb_o      = fg_q;

endmodule

// File: rtl/vid_pattern_gen.sv
// rtl/vid_pattern_gen.sv - video timing and test-pattern generator top: pattern mux and output registers
module vid_pattern_gen
    import vid_pkg::*;
#(
    parameter int TW     = 12,
    parameter int CW     = 8,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic            I_pxl_clk,
    input  logic            I_rst_n,
    input  logic            I_en,
    input  logic [TW-1:0]   I_h_total,
    input  logic [TW-1:0]   I_h_sync,
    input  logic [TW-1:0]   I_h_bporch,
    input  logic [TW-1:0]   I_h_res,
    input  logic [TW-1:0]   I_v_total,
    input  logic [TW-1:0]   I_v_sync,
    input  logic [TW-1:0]   I_v_bporch,
    input  logic [TW-1:0]   I_v_res,
    input  logic [2:0]      I_mode,
    input  logic [3*CW-1:0] I_fg_rgb,
    output logic            O_busy,
    output logic            O_frame_start,
    output logic            O_de,
    output logic            O_hs,
    output logic            O_vs,
    output logic [CW-1:0]   O_r,
    output logic [CW-1:0]   O_g,
    output logic [CW-1:0]   O_b
);

    localparam logic [TW-1:0] ONE = TW'(1);

    function automatic logic [3*CW-1:0] expand(input logic [2:0] m);
        expand = {{CW{m[2]}}, {CW{m[1]}}, {CW{m[0]}}};
    endfunction

    logic            hs, vs, de, busy, fs;
    logic [TW-1:0]   x, bar_w;
    logic [4:0]      y;
    logic [2:0]      mode;
    logic [3*CW-1:0] fg;

    vid_timing_core #(.TW(TW), .CW(CW)) u_core (
        .clk_i         (I_pxl_clk),
        .rst_ni        (I_rst_n),
        .en_i          (I_en),
        .h_total_i     (I_h_total),
        .h_sync_i      (I_h_sync),
        .h_bporch_i    (I_h_bporch),
        .h_res_i       (I_h_res),
        .v_total_i     (I_v_total),
        .v_sync_i      (I_v_sync),
        .v_bporch_i    (I_v_bporch),
        .v_res_i       (I_v_res),
        .mode_i        (I_mode),
        .fg_rgb_i      (I_fg_rgb),
        .hs_o          (hs),
        .vs_o          (vs),
        .de_o          (de),
        .busy_o        (busy),
        .frame_start_o (fs),
        .x_o           (x),
        .y_o           (y),
        .bar_w_o       (bar_w),
        .mode_o        (mode),
        .fg_rgb_o      (fg)
    );

    // Bar index walks 0..8 with a pixel sub-counter; index 8 (or bar_w == 0) is the black tail.
    logic [3:0]    bar_idx_q, bar_idx_d, cur_idx;
    logic [TW-1:0] bar_sub_q, bar_sub_d, cur_sub;
    logic          bar_blank;

    always_comb begin
        cur_idx   = (x == '0) ? 4'd0 : bar_idx_q;
        cur_sub   = (x == '0) ? '0 : bar_sub_q;
        bar_blank = (bar_w == '0) || cur_idx[3];
        bar_idx_d = bar_idx_q;
        bar_sub_d = bar_sub_q;
        if (de) begin
            bar_idx_d = cur_idx;
            bar_sub_d = cur_sub + ONE;
            if (cur_sub == bar_w - ONE) begin
                bar_sub_d = '0;
                if (!cur_idx[3]) bar_idx_d = cur_idx + 4'd1;
            end
        end
    end

    logic [3*CW-1:0] pix, rgb_d, rgb_q;

    always_comb begin
        pix = '0;
        case (mode)
            MODE_SOLID: pix = fg;
            MODE_BARS:  pix = bar_blank ? '0 : expand(bar_colour(cur_idx[2:0]));
            MODE_GRAD:  pix = {3{x[CW-1:0]}};
            MODE_GRID:  pix = ((x[4:0] == '0) || (y == '0)) ? expand(WHITE) : '0;
            MODE_CHECK: pix = (x[4] ^ y[4]) ? expand(WHITE) : '0;
            MODE_CYCLE: pix = expand(bar_colour(x[2:0]));
            default:    pix = '0;
        endcase
        rgb_d = de ? pix : '0;
    end

    logic de_q, hs_q, vs_q, busy_q, fs_q;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            de_q      <= 1'b0;
            hs_q      <= !HS_POL;
            vs_q      <= !VS_POL;
            busy_q    <= 1'b0;
            fs_q      <= 1'b0;
            rgb_q     <= '0;
            bar_idx_q <= '0;
            bar_sub_q <= '0;
        end else begin
            de_q      <= de;
            hs_q      <= HS_POL ? hs : !hs;
            vs_q      <= VS_POL ? vs : !vs;
            busy_q    <= busy;
            fs_q      <= fs;
            rgb_q     <= rgb_d;
            bar_idx_q <= bar_idx_d;
            bar_sub_q <= bar_sub_d;
        end
    end

    assign O_de          = de_q;
    assign O_hs          = hs_q;
    assign O_vs          = vs_q;
    assign O_busy        = busy_q;
    assign O_frame_start = fs_q;
    assign O_r           = rgb_q[CW-1:0];
    assign O_g           = rgb_q[2*CW-1:CW];
    assign O_b           = rgb_q[3*CW-1:2*CW];

endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb/tb_vid_pattern_gen.sv - scoreboard bench for vid_pattern_gen with both sync polarities
module tb_vid_pattern_gen;

    localparam int TW = 12;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [TW-1:0] h_total, h_sync, h_bporch, h_res;
    logic [TW-1:0] v_total, v_sync, v_bporch, v_res;
    logic [2:0]    mode;
    logic [23:0]   fg;

    logic          busy, fs, de, hs, vs;
    logic [7:0]    r, g, b;
    logic          busy2, fs2, de2, hs2, vs2;
    logic [7:0]    r2, g2, b2;

    always #5 clk = ~clk;

    vid_pattern_gen #(.TW(TW), .CW(CW), .HS_POL(1'b1), .VS_POL(1'b1)) u_dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_en(en),
        .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
        .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
        .I_mode(mode), .I_fg_rgb(fg),
        .O_busy(busy), .O_frame_start(fs), .O_de(de), .O_hs(hs), .O_vs(vs),
        .O_r(r), .O_g(g), .O_b(b)
    );

    vid_pattern_gen #(.TW(TW), .CW(CW), .HS_POL(1'b0), .VS_POL(1'b0)) u_dut_neg (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_en(en),
        .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
        .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
        .I_mode(mode), .I_fg_rgb(fg),
        .O_busy(busy2), .O_frame_start(fs2), .O_de(de2), .O_hs(hs2), .O_vs(vs2),
        .O_r(r2), .O_g(g2), .O_b(b2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: {de, hs_active, vs_active, busy, frame_start, {B,G,R}}
    bit          m_run = 1'b0;
    int          m_h = 0, m_v = 0;
    int          s_ht = 0, s_hs = 0, s_hb = 0, s_hr = 0;
    int          s_vt = 0, s_vs = 0, s_vb = 0, s_vr = 0;
    int          s_mode = 0;
    logic [23:0] s_fg = '0;
    logic [28:0] exp_q[$];
    logic        m_lat;

    assign m_lat = rst_n && en && (!m_run || (m_h == s_ht - 1 && m_v == s_vt - 1));

    function automatic logic [23:0] col(input int i);
        case (i)
            0:       col = 24'hffffff;
            1:       col = 24'h00ffff;
            2:       col = 24'hffff00;
            3:       col = 24'h00ff00;
            4:       col = 24'hff00ff;
            5:       col = 24'h0000ff;
            6:       col = 24'hff0000;
            default: col = 24'h000000;
        endcase
    endfunction

    function automatic logic [28:0] model_out();
        int          hs0, vs0, x, y, bw;
        logic        e_de;
        logic [23:0] px;
        logic [7:0]  xb;
        hs0  = s_hs + s_hb;
        vs0  = s_vs + s_vb;
        e_de = m_run && m_h >= hs0 && m_h < hs0 + s_hr && m_v >= vs0 && m_v < vs0 + s_vr;
        x    = m_h - hs0;
        y    = m_v - vs0;
        bw   = s_hr / 8;
        xb   = x[7:0];
        case (s_mode)
            0:       px = s_fg;
            1:       px = (bw == 0 || x < 0 || x / bw > 7) ? 24'h0 : col(x / bw);
            2:       px = {xb, xb, xb};
            3:       px = (x % 32 == 0 || y % 32 == 0) ? 24'hffffff : 24'h0;
            4:       px = (((x >> 4) & 1) != ((y >> 4) & 1)) ? 24'hffffff : 24'h0;
            5:       px = col(x & 7);
            default: px = 24'h0;
        endcase
        if (!e_de) px = 24'h0;
        return {e_de, m_run && m_h < s_hs, m_run && m_v < s_vs, m_run,
                m_run && m_h == 0 && m_v == 0, px};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_h   <= 0;
            m_v   <= 0;
        end else begin
            exp_q.push_back(model_out());
            if (m_lat) begin
                s_ht <= int'(h_total); s_hs <= int'(h_sync); s_hb <= int'(h_bporch); s_hr <= int'(h_res);
                s_vt <= int'(v_total); s_vs <= int'(v_sync); s_vb <= int'(v_bporch); s_vr <= int'(v_res);
                s_mode <= int'(mode);
                s_fg <= fg;
            end
            if (!m_run) begin
                if (en) m_run <= 1'b1;
            end else if (m_h == s_ht - 1) begin
                m_h <= 0;
                if (m_v == s_vt - 1) begin
                    m_v <= 0;
                    if (!en) m_run <= 1'b0;
                end else begin
                    m_v <= m_v + 1;
                end
            end else begin
                m_h <= m_h + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [28:0] e;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_pos", {3'b0, de, hs, vs, busy, fs, b, g, r}, 32'h0);
            chk("rst_neg", {3'b0, de2, hs2, vs2, busy2, fs2, b2, g2, r2}, {3'b0, 5'b01100, 24'h0});
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pos", {3'b0, de, hs, vs, busy, fs, b, g, r}, {3'b0, e});
            chk("sb_neg", {3'b0, de2, hs2, vs2, busy2, fs2, b2, g2, r2},
                {3'b0, e[28], ~e[27], ~e[26], e[25:0]});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_fs(input string tag, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (fs) break;
        end
        chk(tag, {31'b0, fs}, 32'h1);
    endtask

    task automatic wait_de(input string tag, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (de) break;
        end
        chk(tag, {31'b0, de}, 32'h1);
    endtask

    task automatic set_small();
        h_total = 20; h_sync = 2; h_bporch = 3; h_res = 8;
        v_total = 10; v_sync = 1; v_bporch = 2; v_res = 4;
    endtask

    task automatic set_big();
        h_total = 80; h_sync = 4; h_bporch = 4; h_res = 68;
        v_total = 40; v_sync = 2; v_bporch = 2; v_res = 34;
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_de"},   {31'b0, de},    32'h0);
        chk({tag, "_busy"}, {31'b0, busy},  32'h0);
        chk({tag, "_hs"},   {30'b0, hs, vs}, 32'h0);
        chk({tag, "_hsn"},  {30'b0, hs2, vs2}, 32'h3);
        chk({tag, "_rgb"},  {8'b0, b, g, r}, 32'h0);
    endtask

    int first, nde, nhs, fsat, k, nq;

    initial begin
        set_small();
        mode = 3'd1;
        fg   = 24'h123456;
        tick(3);
        check_reset_now("reset");
        rst_n = 1'b1;
        tick(3);
        en = 1'b1;

        wait_fs("fs_first", 10);
        first = -1; nde = 0; nhs = 0; fsat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (de) begin
                nde++;
                if (first < 0) first = i;
            end
            if (hs) nhs++;
            if (fs && fsat < 0) fsat = i;
        end
        chk("first_de", first, 65);
        chk("de_per_frame", nde, 32);
        chk("hs_per_frame", nhs, 20);
        chk("fs_period", fsat, 200);

        tick(50);
        mode = 3'd0;
        wait_fs("fs_solid", 300);
        tick(100);
        fg = 24'habcdef;
        wait_de("de_solid", 100);
        chk("solid_held", {8'b0, b, g, r}, 32'h123456);
        wait_fs("fs_solid2", 300);
        wait_de("de_solid2", 100);
        chk("solid_new", {8'b0, b, g, r}, 32'habcdef);

        set_big();
        for (int m = 1; m <= 7; m++) begin
            mode = 3'(m);
            wait_fs("fs_mode", 4000);
        end

        set_small();
        mode = 3'd5;
        wait_fs("fs_stop", 4000);
        tick(100);
        en = 1'b0;
        k = 99;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            k++;
            if (!busy) break;
        end
        chk("busy_fall", k, 200);
        nq = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            nq += int'(fs) + int'(de);
        end
        chk("idle_quiet", nq, 0);
        en = 1'b1;
        wait_fs("fs_restart", 10);
        chk("restart_busy", {31'b0, busy}, 32'h1);

        wait_de("de_pre_rst", 300);
        #1 rst_n = 1'b0;
        #1 check_reset_now("async");
        tick(2);
        rst_n = 1'b1;
        wait_fs("fs_recover", 10);
        first = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (de) begin
                first = i;
                break;
            end
        end
        chk("recover_first_de", first, 65);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
